// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART controller FIFO blocks.
// Trigger-level encodings, timeout FSM states and the trigger threshold helper.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_Q  = 2'd1,
    TRIG_H  = 2'd2,
    TRIG_NF = 2'd3
  } trig_lvl_e;

  typedef enum logic [1:0] {
    TO_IDLE    = 2'd0,
    TO_ARMED   = 2'd1,
    TO_EXPIRED = 2'd2
  } to_state_e;

  localparam int unsigned TO_CHARS_DEF = 4;

  // Occupancy at which the trigger fires for a FIFO of the given depth.
  function automatic int unsigned trig_threshold(input trig_lvl_e lvl, input int unsigned depth);
    int unsigned thr;
    case (lvl)
      TRIG_1:  thr = 1;
      TRIG_Q:  thr = depth / 4;
      TRIG_H:  thr = depth / 2;
      TRIG_NF: thr = depth - 2;
      default: thr = 1;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/uart_fifo_timeout.sv
// Character-timeout FSM: counts idle character times while the FIFO holds data
// and flags a pending timeout after TO_CHARS of them with no push/pop activity.
module uart_fifo_timeout
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TO_CHARS = TO_CHARS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic nonempty,
  input  logic activity,
  input  logic char_tick,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TO_CHARS + 1);

  to_state_e         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;

  // nonempty reflects the occupancy after this edge, so the FSM tracks fifo_ptr
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr || !nonempty) begin
      state_nxt = TO_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        TO_IDLE: begin
          state_nxt = TO_ARMED;
          cnt_nxt   = '0;
        end
        TO_ARMED: begin
          if (activity) begin
            cnt_nxt = '0;
          end else if (char_tick) begin
            if (cnt == CW'(TO_CHARS - 1)) begin
              state_nxt = TO_EXPIRED;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        TO_EXPIRED: begin
          if (activity) begin
            state_nxt = TO_ARMED;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = TO_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TO_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign timeout = (state == TO_EXPIRED);

endmodule

// File: rtl/uart_fifo_ptr_ctrl.sv
// Pointer, occupancy and status controller for one UART FIFO; the storage RAM
// is external and addressed through wr_ptr/rd_ptr.
module uart_fifo_ptr_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned TO_CHARS = TO_CHARS_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_lvl,
  input  logic          char_tick,
  input  logic          ovr_clr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          ram_we,
  output logic [AW:0]   fifo_ptr,
  output logic          full,
  output logic          empty,
  output logic          trig_hit,
  output logic          overrun,
  output logic          underrun,
  output logic          timeout
);

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count, count_nxt;
  logic [AW:0]   thr;
  logic          ovr_q;
  logic          live, push_ok, pop_ok, ovr_evt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    thr = (AW+1)'(trig_threshold(trig_lvl_e'(trig_lvl), DEPTH));
  end
  assign trig_hit = (count >= thr);

  // reset and fifo_clr both swallow any request presented in the same cycle
  assign live     = ~reset & ~fifo_clr;
  assign pop_ok   = live & pop & ~empty;
  assign push_ok  = live & push & (~full | pop_ok);
  assign ovr_evt  = live & push & full & ~pop_ok;
  assign ram_we   = push_ok;
  assign underrun = live & pop & empty;

  always_comb begin
    count_nxt = count;
    if (fifo_clr) begin
      count_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
      ovr_q <= 1'b0;
    end else if (fifo_clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count <= count_nxt;
      // a fresh overrun event wins over a simultaneous clear
      ovr_q <= (ovr_q & ~ovr_clr) | ovr_evt;
    end
  end

  uart_fifo_timeout #(
    .TO_CHARS(TO_CHARS)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr      (fifo_clr),
    .nonempty (count_nxt != '0),
    .activity (push_ok | pop_ok),
    .char_tick(char_tick),
    .timeout  (timeout)
  );

  assign wr_ptr   = wr_q;
  assign rd_ptr   = rd_q;
  assign fifo_ptr = count;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_fifo_ptr_ctrl.sv
// Self-checking bench for uart_fifo_ptr_ctrl: directed scenarios then random
// traffic, compared against an occupancy/idle-time reference model.
module tb_uart_fifo_ptr_ctrl;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int TO_CHARS = 4;

  logic          clock = 1'b0;
  logic          reset, push, pop, fifo_clr, char_tick, ovr_clr;
  logic [1:0]    trig_lvl;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_ptr;
  logic          ram_we, full, empty, trig_hit, overrun, underrun, timeout;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int occ, wp, rp, idle;
  bit ovr;

  always #5 clock = ~clock;

  uart_fifo_ptr_ctrl #(
    .DEPTH(DEPTH),
    .TO_CHARS(TO_CHARS)
  ) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .fifo_clr(fifo_clr),
    .trig_lvl(trig_lvl), .char_tick(char_tick), .ovr_clr(ovr_clr),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .ram_we(ram_we), .fifo_ptr(fifo_ptr),
    .full(full), .empty(empty), .trig_hit(trig_hit), .overrun(overrun),
    .underrun(underrun), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int thr_of(input logic [1:0] t);
    case (t)
      2'd0:    return 1;
      2'd1:    return DEPTH / 4;
      2'd2:    return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic check_regs();
    chk("fifo_ptr", fifo_ptr, occ);
    chk("wr_ptr", wr_ptr, wp);
    chk("rd_ptr", rd_ptr, rp);
    chk("full", full, occ == DEPTH);
    chk("empty", empty, occ == 0);
    chk("trig_hit", trig_hit, occ >= thr_of(trig_lvl));
    chk("overrun", overrun, ovr);
    chk("timeout", timeout, occ != 0 && idle >= TO_CHARS);
  endtask

  // Called just after a rising edge: applies one cycle of inputs.
  task automatic step(input bit p, input bit q, input bit c, input logic [1:0] t,
                      input bit k, input bit oc);
    bit e_empty, e_full, pop_a, push_a, ovr_evt;
    push = p; pop = q; fifo_clr = c; trig_lvl = t; char_tick = k; ovr_clr = oc;
    e_empty = (occ == 0);
    e_full  = (occ == DEPTH);
    pop_a   = !c && q && !e_empty;
    push_a  = !c && p && (!e_full || pop_a);
    ovr_evt = !c && p && e_full && !pop_a;
    @(negedge clock);
    chk("ram_we", ram_we, push_a);
    chk("underrun", underrun, !c && q && e_empty);
    @(posedge clock);
    #1;
    if (c) begin
      occ = 0; wp = 0; rp = 0; ovr = 0; idle = 0;
    end else begin
      if (push_a) wp = (wp + 1) % DEPTH;
      if (pop_a)  rp = (rp + 1) % DEPTH;
      occ = occ + int'(push_a) - int'(pop_a);
      ovr = (ovr && !oc) || ovr_evt;
      if (occ == 0 || push_a || pop_a) idle = 0;
      else if (k && idle < 1000) idle++;
    end
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b1; pop = 1'b1; fifo_clr = 1'b0; char_tick = 1'b1; ovr_clr = 1'b0;
    @(negedge clock);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clock);
    #1;
    occ = 0; wp = 0; rp = 0; ovr = 0; idle = 0;
    check_regs();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    trig_lvl = 2'd0;
    do_reset();

    // fill to full, wrap wr_ptr, then overrun
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 2'd0, 0, 0);
    chk("fill_ptr", fifo_ptr, 16);
    chk("fill_full", full, 1);
    chk("fill_wrap", wr_ptr, 0);
    step(1, 0, 0, 2'd0, 0, 0);
    chk("ovr_set", overrun, 1);
    step(0, 0, 0, 2'd0, 0, 1);
    chk("ovr_clr", overrun, 0);

    // full with simultaneous push and pop
    step(1, 1, 0, 2'd0, 0, 0);
    chk("full_pp_ptr", fifo_ptr, 16);
    chk("full_pp_rd", rd_ptr, 1);
    chk("full_pp_ovr", overrun, 0);

    // overrun event beats simultaneous ovr_clr
    step(1, 0, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 1);
    chk("ovr_race", overrun, 1);

    // drain to 10 entries, then flush with push asserted
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2'd0, 0, 0);
    chk("ten_ptr", fifo_ptr, 10);
    step(1, 0, 1, 2'd0, 0, 0);
    chk("clr_ptr", fifo_ptr, 0);
    chk("clr_ovr", overrun, 0);
    chk("clr_wr", wr_ptr, 0);

    // underrun cases
    step(0, 1, 0, 2'd0, 0, 0);
    chk("udr_rd", rd_ptr, 0);
    step(1, 1, 0, 2'd0, 0, 0);
    chk("udr_pp_ptr", fifo_ptr, 1);

    // half trigger
    step(0, 0, 1, 2'd2, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 2'd2, 0, 0);
    chk("trig7", trig_hit, 0);
    step(1, 0, 0, 2'd2, 0, 0);
    chk("trig8", trig_hit, 1);
    step(0, 1, 0, 2'd2, 0, 0);
    chk("trig_pop", trig_hit, 0);

    // character timeout
    step(0, 0, 1, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < TO_CHARS; i++) step(0, 0, 0, 2'd0, 1, 0);
    chk("to_set", timeout, 1);
    step(0, 1, 0, 2'd0, 0, 0);
    chk("to_pop", timeout, 0);
    chk("to_pop_ptr", fifo_ptr, 2);
    step(0, 1, 0, 2'd0, 1, 0);
    step(0, 1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 2'd0, 1, 0);
    chk("to_idle", timeout, 0);

    // random traffic, alternating fill-biased and drain-biased phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
        end else begin
          step($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30),
               $urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75),
               $urandom_range(0, 63) == 0,
               2'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 40,
               $urandom_range(0, 7) == 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ptr_ctrl.md
# uart_fifo_ptr_ctrl

Pointer and level controller for one UART FIFO (instantiated once for TX, once for RX in the UART controller). Owns write/read pointers, occupancy count, full/empty, trigger-level detection, overrun/underrun flags and the RX character-timeout state machine; the storage RAM is external and addressed by this block. The occupancy output is the signal the white-box coverage interface samples as the FIFO pointer.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥4
- AW, $clog2(DEPTH), pointer width
- TO_CHARS, 4, idle character times before timeout
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- push  in  1  write request (data to RAM at wr_ptr same cycle)
- pop  in  1  read request (data from RAM at rd_ptr)
- fifo_clr  in  1  flush pointers/count/flags
- trig_lvl  in  2  trigger select
- char_tick  in  1  one-cycle pulse per character time from baud generator
- ovr_clr  in  1  clear sticky overrun
- wr_ptr  out  AW  RAM write address
- rd_ptr  out  AW  RAM read address
- ram_we  out  1  accepted push (combinational: push & ~blocked)
- fifo_ptr  out  AW+1  occupancy 0..DEPTH
- full / empty  out  1  each
- trig_hit  out  1  fifo_ptr ≥ selected threshold
- overrun  out  1  sticky; push while full without pop
- underrun  out  1  one-cycle pulse; pop while empty
- timeout  out  1  character timeout pending

## Operation
- Thresholds: trig_lvl 0→1, 1→DEPTH/4, 2→DEPTH/2, 3→DEPTH-2 (16: 1,4,8,14).
- Priority: reset > fifo_clr > push/pop.
- fifo_clr: pointers, fifo_ptr, overrun, timeout FSM to IDLE; push/pop that cycle ignored.
- Push accepted if ~full, or full with accepted pop. Pop accepted if ~empty.
- Both accepted: both pointers advance, fifo_ptr unchanged.
- Empty + push + pop: push accepted, pop rejected, underrun pulses, fifo_ptr→1.
- Full + push, no pop: push dropped, wr_ptr holds, overrun set until ovr_clr or fifo_clr; ovr_clr and a new overrun event in same cycle → overrun stays 1.
- Pointers wrap DEPTH-1→0 (AW-bit natural wrap). fifo_ptr never exceeds DEPTH or goes below 0.
- Timeout FSM: IDLE (fifo_ptr==0) → ARMED when fifo_ptr≠0; ARMED counts char_tick, counter cleared by any accepted push/pop; count reaching TO_CHARS → EXPIRED (timeout=1). EXPIRED → ARMED on accepted push/pop (counter 0), → IDLE when fifo_ptr becomes 0 or fifo_clr. char_tick with simultaneous accepted push/pop: counter clears, tick not counted.

## Timing
- All outputs except ram_we and underrun registered; update the cycle after the request edge.
- Reset values: wr_ptr=0, rd_ptr=0, fifo_ptr=0, empty=1, full=0, trig_hit=0, overrun=0, underrun=0, timeout=0, ram_we=0 (while reset high), FSM IDLE, counter 0.
- underrun is combinational from pop & empty; ram_we combinational from push and registered state.
- full/empty/trig_hit derived from registered fifo_ptr, consistent with it every cycle.
- timeout asserts the cycle after the TO_CHARS-th counted tick.
- Reset mid-operation: all state to reset values next edge; requests during reset ignored.

## Structure
- uart_ctrl_pkg: trig_lvl enum (TRIG_1, TRIG_Q, TRIG_H, TRIG_NF), timeout state enum (TO_IDLE, TO_ARMED, TO_EXPIRED), default TO_CHARS constant.
- Sub-module uart_fifo_timeout: FSM + char counter; inputs clock, reset, clr, nonempty, activity, char_tick; output timeout.

## Test plan
- Reset, then 16 pushes, no pops → fifo_ptr 1..16, full=1 after 16th, wr_ptr wraps to 0; 17th push → ram_we=0, overrun=1.
- Full FIFO, push+pop same cycle → fifo_ptr stays 16, both pointers advance by 1, overrun stays 0.
- Empty, pop alone → underrun one-cycle pulse, rd_ptr stays 0; empty+push+pop → fifo_ptr=1, underrun pulses.
- trig_lvl=2, push 7 → trig_hit=0; 8th → trig_hit=1; pop → 0.
- Push 3, then 4 char_tick without activity → timeout=1 after 4th; one pop → timeout=0, fifo_ptr=2; pop 2 → FSM IDLE, further ticks no timeout.
- fifo_clr with push asserted while 10 entries and overrun set → next cycle fifo_ptr=0, empty=1, overrun=0, pointers 0.
